mfp_ahb_lite_master: RTL and testbench
======================================

Name: mfp_ahb_lite_master

Overview:
Single-transfer AHB-Lite bus master (initiator) that turns a simple command/response stream into AHB-Lite NONSEQ word transfers on the MFP system bus. It is the initiator end for the memory-mapped slaves on that bus (GPIO, Rojobot registers, 7-segment). Consumers include a bus-test driver and future DMA/bridge logic. Address and data phases are pipelined, giving one transfer per cycle at zero wait states.

Parameters:
ADDR_W, 32, width of HADDR and cmd_addr
DATA_W, 32, width of HWDATA/HRDATA/cmd_wdata/rsp_rdata (only 32 supported; HSIZE fixed word)
ERR_CANCEL, 0, 1 = cancel a pending address phase on the first error-response cycle and report it as an error without a bus access

Ports:
HCLK  in  1  system clock
HRESET  in  1  asynchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when valid && ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address (word-aligned; bits [1:0] forwarded unchanged)
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse per completed command, in command order
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  HRESP=ERROR for this command (or cancelled)
busy  out  1  any transfer in address or data phase
HADDR  out  ADDR_W  AHB address
HTRANS  out  2  IDLE=2'b00 / NONSEQ=2'b10 only
HWRITE  out  1  AHB write
HSIZE  out  3  constant 3'b010
HBURST  out  3  constant 3'b000 (SINGLE)
HWDATA  out  DATA_W  AHB write data
HRDATA  in  DATA_W  AHB read data
HREADY  in  1  system HREADY (slave mux output)
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Two stage registers. Address stage (a_valid, a_addr, a_write, a_wdata) drives HADDR/HWRITE/HTRANS. Data stage (d_valid, d_write, d_wdata) drives HWDATA. All bus outputs are registered.
- Reset (async, HRESET=1): a_valid=d_valid=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. cmd_ready=1 after reset. A transfer in flight at reset is abandoned with no response.
- cmd_ready = !a_valid || HREADY (combinational). Accept at edge T: next cycle HTRANS=NONSEQ, HADDR=cmd_addr, HWRITE=cmd_write.
- Address phase completes on an edge with a_valid && HREADY. The command moves to the data stage and HWDATA<=a_wdata. If no new command is accepted on that edge, HTRANS<=IDLE.
- While HREADY=0, HADDR/HTRANS/HWRITE/HWDATA are held stable.
- Data phase completes on an edge with d_valid && HREADY:
  - rsp_valid<=1 next cycle.
  - rsp_rdata<=HRDATA for reads, 0 for writes.
  - rsp_err<=HRESP.
  - rsp_valid otherwise 0; rsp_rdata/rsp_err hold last values.
- Latency with zero wait states: accept at edge T → NONSEQ in cycle T+1 → data phase T+2 → rsp_valid in T+3. Back-to-back throughput is 1 per cycle.
- Error (two-cycle): cycle 1 HRESP=1, HREADY=0; cycle 2 HRESP=1, HREADY=1 → rsp_err=1 for that command.
  - ERR_CANCEL=0: the pending address phase stays NONSEQ and proceeds normally.
  - ERR_CANCEL=1: on cycle 1, HTRANS<=IDLE and the pending command is marked cancelled. It gives rsp_valid with rsp_err=1 and rsp_rdata=0 one cycle after the erroring response, and is never issued on the bus.
- Simultaneous accept plus address completion plus data completion on one edge is legal and required (full pipeline).
- busy = a_valid || d_valid.
- No response backpressure: the consumer must take rsp_valid every cycle.

Decomposition:
- Shared package/header (mfp_ahb_const.vh): HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE, HRESP_OKAY/ERROR.
- No sub-module. Both stages are small enough to live in one module.

Test Plan:
- Reset then single read of 0x1F700004 with slave returning 0x0000A5A5 and zero waits → NONSEQ one cycle after accept; rsp_valid 3 cycles after accept with rsp_rdata=0x0000A5A5, rsp_err=0.
- Write 0x12345678 to 0x1F700000 with 2 wait states → HWDATA=0x12345678 held stable through all 3 data-phase cycles; single rsp_valid with rsp_rdata=0; HADDR of the queued next command held during waits.
- Four back-to-back reads, zero waits → cmd_ready stays 1; HTRANS=NONSEQ 4 consecutive cycles; 4 consecutive rsp_valid pulses in order.
- Error on a write followed by a pending read, ERR_CANCEL=0 → first rsp_err=1; read then completes with rsp_err=0. With ERR_CANCEL=1 → HTRANS=IDLE in the second error cycle; read is never issued and reports rsp_err=1, rsp_rdata=0.
- HRESET asserted mid data phase with HREADY=0 → same cycle HTRANS=IDLE, HWDATA=0, busy=0; no rsp_valid after release.
- cmd_valid held while HREADY=0 with a_valid=1 → cmd_ready=0, no new accept; accept occurs on the HREADY=1 edge.

Source files
------------

// File: rtl/mfp_ahb_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_master_pkg
//   AHB-Lite encodings used by the MFP bus master: transfer types, the fixed
//   word size and SINGLE burst, and response codes. Also a small helper that
//   maps "this stage should appear on the bus" onto an HTRANS value.
// ---------------------------------------------------------------------------
package mfp_ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Only single word transfers are issued, so HTRANS is IDLE or NONSEQ.
    function automatic logic [1:0] htrans_for(input logic issue);
        return issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// mfp_ahb_lite_master
//   Single-transfer AHB-Lite initiator. Commands (cmd_*) are turned into
//   NONSEQ word transfers; one response (rsp_*) is returned per command in
//   order. Address and data phases are pipelined so zero-wait-state slaves
//   sustain one transfer per cycle.
//
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command stream (valid/ready handshake)
//   rsp_valid/rdata/err     response pulse, read data (0 for writes), error
//   busy                    a transfer is in its address or data phase
//   HADDR..HWDATA           registered AHB-Lite master outputs
//   HRDATA, HREADY, HRESP   AHB-Lite inputs (HREADY is the system HREADY)
//
// Only DATA_W = 32 is meaningful: HSIZE is fixed to a word.
// ---------------------------------------------------------------------------
module mfp_ahb_lite_master
    import mfp_ahb_lite_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ERR_CANCEL = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    // Address stage
    logic              a_valid_q, a_valid_d;
    logic              a_cancel_q, a_cancel_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic              a_write_q, a_write_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic [1:0]        htrans_q, htrans_d;

    // Data stage (hwdata_q is the data-stage write data driven on HWDATA)
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic              d_cancel_q, d_cancel_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    // Response
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic accept;
    logic a_done;
    logic d_done;
    logic cancel_now;

    assign cmd_ready = !a_valid_q || HREADY;
    assign accept    = cmd_valid && cmd_ready;
    assign a_done    = a_valid_q && HREADY;
    // A cancelled entry never reached the bus, so it retires on the next edge
    // without waiting for the slave.
    assign d_done    = d_valid_q && (HREADY || d_cancel_q);

    // First cycle of a two-cycle ERROR response (HRESP=1, HREADY=0): AHB
    // allows the master to drop the pending address phase to IDLE here.
    assign cancel_now = (ERR_CANCEL != 0) && d_valid_q && !d_cancel_q &&
                        (HRESP == HRESP_ERROR) && !HREADY &&
                        a_valid_q && !a_cancel_q;

    always_comb begin
        a_valid_d  = a_valid_q;
        a_cancel_d = a_cancel_q;
        a_addr_d   = a_addr_q;
        a_write_d  = a_write_q;
        a_wdata_d  = a_wdata_q;

        if (accept) begin
            a_valid_d  = 1'b1;
            a_cancel_d = 1'b0;
            a_addr_d   = cmd_addr;
            a_write_d  = cmd_write;
            a_wdata_d  = cmd_wdata;
        end else if (a_done) begin
            a_valid_d  = 1'b0;
            a_cancel_d = 1'b0;
        end else if (cancel_now) begin
            a_cancel_d = 1'b1;
        end

        htrans_d = htrans_for(a_valid_d && !a_cancel_d);
    end

    always_comb begin
        d_valid_d  = d_valid_q;
        d_write_d  = d_write_q;
        d_cancel_d = d_cancel_q;
        hwdata_d   = hwdata_q;

        // Whenever the address stage advances, any data-stage entry retires
        // on the same edge, so the data stage can simply be overwritten.
        if (a_done) begin
            d_valid_d  = 1'b1;
            d_write_d  = a_write_q;
            d_cancel_d = a_cancel_q;
            // A cancelled command never drives the bus; keep HWDATA steady.
            if (!a_cancel_q) begin
                hwdata_d = a_wdata_q;
            end
        end else if (d_done) begin
            d_valid_d  = 1'b0;
            d_cancel_d = 1'b0;
        end
    end

    always_comb begin
        rsp_valid_d = d_done;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (d_done) begin
            if (d_cancel_q) begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end else begin
                rsp_rdata_d = d_write_q ? '0 : HRDATA;
                rsp_err_d   = (HRESP == HRESP_ERROR);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid_q   <= 1'b0;
            a_cancel_q  <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_wdata_q   <= '0;
            htrans_q    <= HTRANS_IDLE;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_cancel_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_cancel_q  <= a_cancel_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_wdata_q   <= a_wdata_d;
            htrans_q    <= htrans_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_cancel_q  <= d_cancel_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HADDR     = a_addr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = a_valid_q || d_valid_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_lite_master
//   Directed bench for the AHB-Lite master. Two instances share all inputs:
//   dut0 with ERR_CANCEL=0 and dut1 with ERR_CANCEL=1. The bench plays the
//   slave by driving HREADY/HRESP/HRDATA cycle by cycle. Inputs change 1 ns
//   after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mfp_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;

    logic        cmd_ready, rsp_valid, rsp_err, busy, HWRITE;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;

    logic        c_cmd_ready, c_rsp_valid, c_rsp_err, c_busy, c_HWRITE;
    logic [31:0] c_rsp_rdata, c_HADDR, c_HWDATA;
    logic [1:0]  c_HTRANS;
    logic [2:0]  c_HSIZE, c_HBURST;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    mfp_ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CANCEL(0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    mfp_ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .ERR_CANCEL(1)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(c_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err),
        .busy(c_busy), .HADDR(c_HADDR), .HTRANS(c_HTRANS), .HWRITE(c_HWRITE),
        .HSIZE(c_HSIZE), .HBURST(c_HBURST), .HWDATA(c_HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // One line per completed transaction.
    always @(posedge HCLK) begin
        if (rsp_valid)
            $display("[%0t] dut0 rsp rdata=%08h err=%0b", $time, rsp_rdata, rsp_err);
        if (c_rsp_valid)
            $display("[%0t] dut1 rsp rdata=%08h err=%0b", $time, c_rsp_rdata, c_rsp_err);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        HRESET = 1'b1;
        tick(); tick();
        n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL rst_htrans: got %b exp 00", HTRANS); end
        n_cmp++; if (HADDR !== 32'h0) begin n_bad++; $display("FAIL rst_haddr: got %h exp 0", HADDR); end
        n_cmp++; if (HWRITE !== 1'b0 || HWDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hwrite_hwdata: got %b/%h exp 0/0", HWRITE, HWDATA); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp: got %b/%h/%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_err); end
        n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_busy_ready: got %b/%b exp 0/1", busy, cmd_ready); end
        n_cmp++; if (HSIZE !== 3'b010 || HBURST !== 3'b000) begin n_bad++; $display("FAIL rst_hsize_hburst: got %b/%b exp 010/000", HSIZE, HBURST); end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1F70_0004;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %b exp 1", cmd_ready); end
        tick();                                     // accept edge T
        cmd_valid = 1'b0;
        n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h1F70_0004 || HWRITE !== 1'b0) begin n_bad++; $display("FAIL rd_addr_phase: got %b/%h/%b exp 10/1f700004/0", HTRANS, HADDR, HWRITE); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy: got %b exp 1", busy); end
        tick();                                     // T+1: address phase done
        n_cmp++; if (HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_data_phase: got htrans %b rsp_valid %b exp 00/0", HTRANS, rsp_valid); end
        HRDATA = 32'h0000_A5A5;
        tick();                                     // T+2: data phase done
        HRDATA = 32'h0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_A5A5 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_rsp: got %b/%h/%b exp 1/0000a5a5/0", rsp_valid, rsp_rdata, rsp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle_busy: got %b exp 0", busy); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0000_A5A5) begin n_bad++; $display("FAIL rd_rsp_pulse: got %b/%h exp 0/0000a5a5", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_write_waits;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1F70_0000; cmd_wdata = 32'h1234_5678;
        tick();
        cmd_write = 1'b0; cmd_addr = 32'h1F70_0008; cmd_wdata = 32'h0;  // queued read
        #1;
        n_cmp++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_addr_phase: got %b/%b/%b exp 10/1/1", HTRANS, HWRITE, cmd_ready); end
        tick();
        cmd_valid = 1'b0; HREADY = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #1;
            n_cmp++; if (HWDATA !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_hwdata_c%0d: got %h exp 12345678", w, HWDATA); end
            n_cmp++; if (HADDR !== 32'h1F70_0008 || HTRANS !== 2'b10 || HWRITE !== 1'b0) begin n_bad++; $display("FAIL wr_next_hold_c%0d: got %h/%b/%b exp 1f700008/10/0", w, HADDR, HTRANS, HWRITE); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_no_rsp_c%0d: got %b exp 0", w, rsp_valid); end
            if (w == 0) begin
                n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_wait: got %b exp 0", cmd_ready); end
            end
            if (w == 2) begin HREADY = 1'b1; HRDATA = 32'hDEAD_BEEF; end
            tick();
        end
        HRDATA = 32'h0BAD_F00D;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_rsp: got %b/%h/%b exp 1/0/0", rsp_valid, rsp_rdata, rsp_err); end
        tick();
        HRDATA = 32'h0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL wr_next_rsp: got %b/%h exp 1/0badf00d", rsp_valid, rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL wr_done: got %b/%b exp 0/0", rsp_valid, busy); end
    endtask

    task automatic test_back_to_back;
        // Read i: accepted at end of cycle i, NONSEQ in i+1, data in i+2, rsp in i+3.
        for (int k = 0; k < 8; k++) begin
            if (k >= 1 && k <= 4) begin
                n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 32'h1F70_0010 + 32'(4*(k-1))) begin n_bad++; $display("FAIL b2b_addr_c%0d: got %b/%h exp 10/%h", k, HTRANS, HADDR, 32'h1F70_0010 + 32'(4*(k-1))); end
            end else begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_c%0d: got %b exp 00", k, HTRANS); end
            end
            if (k >= 3 && k <= 6) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB000_0000 + 32'(k-3)) begin n_bad++; $display("FAIL b2b_rsp_c%0d: got %b/%h exp 1/%h", k, rsp_valid, rsp_rdata, 32'hB000_0000 + 32'(k-3)); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_norsp_c%0d: got %b exp 0", k, rsp_valid); end
            end
            cmd_valid = (k < 4);
            cmd_write = 1'b0;
            cmd_addr  = 32'h1F70_0010 + 32'(4*k);
            HRDATA    = (k >= 2 && k <= 5) ? 32'hB000_0000 + 32'(k-2) : 32'h0;
            #1;
            if (k < 4) begin
                n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_c%0d: got %b exp 1", k, cmd_ready); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_error;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1F70_0020; cmd_wdata = 32'h0000_0055;
        tick();
        cmd_write = 1'b0; cmd_addr = 32'h1F70_0024;
        tick();
        cmd_valid = 1'b0; HRESP = 1'b1; HREADY = 1'b0;         // error cycle 1
        n_cmp++; if (HTRANS !== 2'b10 || c_HTRANS !== 2'b10) begin n_bad++; $display("FAIL err_c1_htrans: got %b/%b exp 10/10", HTRANS, c_HTRANS); end
        tick();
        HREADY = 1'b1;                                          // error cycle 2
        n_cmp++; if (HTRANS !== 2'b10) begin n_bad++; $display("FAIL err_keep_nonseq: got %b exp 10", HTRANS); end
        n_cmp++; if (c_HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_cancel_idle: got %b exp 00", c_HTRANS); end
        tick();
        HRESP = 1'b0; HRDATA = 32'h0000_CAFE;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL err_rsp0: got %b/%b/%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (c_rsp_valid !== 1'b1 || c_rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_rsp1: got %b/%b exp 1/1", c_rsp_valid, c_rsp_err); end
        n_cmp++; if (HTRANS !== 2'b00 || c_HTRANS !== 2'b00) begin n_bad++; $display("FAIL err_after_htrans: got %b/%b exp 00/00", HTRANS, c_HTRANS); end
        tick();
        HRDATA = 32'h0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_CAFE) begin n_bad++; $display("FAIL err_read_ok0: got %b/%b/%h exp 1/0/0000cafe", rsp_valid, rsp_err, rsp_rdata); end
        n_cmp++; if (c_rsp_valid !== 1'b1 || c_rsp_err !== 1'b1 || c_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL err_read_cancel1: got %b/%b/%h exp 1/1/0", c_rsp_valid, c_rsp_err, c_rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || c_rsp_valid !== 1'b0 || busy !== 1'b0 || c_busy !== 1'b0) begin n_bad++; $display("FAIL err_done: got %b/%b/%b/%b exp 0/0/0/0", rsp_valid, c_rsp_valid, busy, c_busy); end
    endtask

    task automatic test_reset_mid_data;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1F70_0030; cmd_wdata = 32'hA1A1_A1A1;
        tick();
        cmd_valid = 1'b0;
        tick();
        HREADY = 1'b0;
        #1;
        n_cmp++; if (HWDATA !== 32'hA1A1_A1A1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got %h/%b exp a1a1a1a1/1", HWDATA, busy); end
        HRESET = 1'b1;
        #1;
        n_cmp++; if (HTRANS !== 2'b00 || HWDATA !== 32'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_async_rst: got %b/%h/%b exp 00/0/0", HTRANS, HWDATA, busy); end
        tick();
        #2 HRESET = 1'b0; HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp_c%0d: got %b/%b exp 0/0", i, rsp_valid, busy); end
        end
    endtask

    task automatic test_hold_cmd;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1F70_0040;
        tick();
        cmd_addr = 32'h1F70_0044; HREADY = 1'b0;
        for (int w = 0; w < 2; w++) begin
            #1;
            n_cmp++; if (cmd_ready !== 1'b0 || HADDR !== 32'h1F70_0040) begin n_bad++; $display("FAIL hold_c%0d: got ready %b haddr %h exp 0/1f700040", w, cmd_ready, HADDR); end
            tick();
        end
        HREADY = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready: got %b exp 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; HRDATA = 32'h0000_4040;
        n_cmp++; if (HADDR !== 32'h1F70_0044 || HTRANS !== 2'b10) begin n_bad++; $display("FAIL hold_accept: got %h/%b exp 1f700044/10", HADDR, HTRANS); end
        tick();
        HRDATA = 32'h0000_4444;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_4040) begin n_bad++; $display("FAIL hold_rsp0: got %b/%h exp 1/00004040", rsp_valid, rsp_rdata); end
        tick();
        HRDATA = 32'h0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_4444) begin n_bad++; $display("FAIL hold_rsp1: got %b/%h exp 1/00004444", rsp_valid, rsp_rdata); end
        tick();
    endtask

    initial begin
        idle_inputs();
        HRESET = 1'b1;
        #1;
        test_reset();
        test_single_read();
        test_write_waits();
        test_back_to_back();
        test_error();
        test_reset_mid_data();
        test_hold_cmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
